// File: rtl/nco_sweep_ctrl.sv
// NCO phase-increment sweep controller.
// Steps phase_incr from start_incr toward stop_incr in step-sized moves,
// holding each value for dwell+1 cycles, optionally returning to start_incr.
//
// state | meaning
// IDLE  | waiting for start; phase_incr holds its last value
// DWELL | sweep active; holding a value or advancing to the next one
// DONE  | one-cycle completion pulse, then back to IDLE
module nco_sweep_ctrl #(
   parameter int INCR_W  = 7,
   parameter int DWELL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [INCR_W-1:0] start_incr,
   input  logic [INCR_W-1:0] stop_incr,
   input  logic [INCR_W-1:0] step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic              pingpong,
   output logic [INCR_W-1:0] phase_incr,
   output logic              incr_valid,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

   state_t               state, state_nxt;
   logic [INCR_W-1:0]    cfg_start, cfg_step;
   logic [DWELL_W-1:0]   cfg_dwell;
   logic                 cfg_pp;
   logic [INCR_W-1:0]    target, target_nxt;
   logic                 leg, leg_nxt;
   logic [DWELL_W-1:0]   dwell_cnt, cnt_nxt;
   logic [INCR_W-1:0]    phase_nxt;
   logic                 iv_nxt;
   logic                 load_cfg;

   logic [INCR_W-1:0]    tgt_sel;
   logic [INCR_W-1:0]    step_eff;
   logic [INCR_W:0]      cur_w, tgt_w, diff_w, step_w;
   logic [INCR_W-1:0]    next_val;

   // Next value toward the active target; when the current target is reached
   // the return leg's target (cfg_start) is used so the turn happens in one cycle.
   always_comb begin
      tgt_sel  = (phase_incr == target) ? cfg_start : target;
      step_eff = (cfg_step == '0) ? {{(INCR_W-1){1'b0}}, 1'b1} : cfg_step;
      cur_w    = {1'b0, phase_incr};
      tgt_w    = {1'b0, tgt_sel};
      step_w   = {1'b0, step_eff};
      diff_w   = (tgt_w > cur_w) ? (tgt_w - cur_w) : (cur_w - tgt_w);
      if (diff_w <= step_w)
         next_val = tgt_sel;
      else if (tgt_w > cur_w)
         next_val = phase_incr + step_eff;
      else
         next_val = phase_incr - step_eff;
   end

   // Next-state and datapath update decisions.
   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase_incr;
      cnt_nxt    = dwell_cnt;
      target_nxt = target;
      leg_nxt    = leg;
      iv_nxt     = 1'b0;
      load_cfg   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt  = DWELL;
               phase_nxt  = start_incr;
               cnt_nxt    = dwell;
               target_nxt = stop_incr;
               leg_nxt    = 1'b0;
               iv_nxt     = 1'b1;
               load_cfg   = 1'b1;
            end
         end
         DWELL: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (dwell_cnt != '0) begin
               cnt_nxt = dwell_cnt - 1'b1;
            end else if (phase_incr != target || (cfg_pp && !leg)) begin
               if (phase_incr == target) begin
                  target_nxt = cfg_start;
                  leg_nxt    = 1'b1;
               end
               phase_nxt = next_val;
               cnt_nxt   = cfg_dwell;
               // A turn at equal endpoints re-holds the same value; not a new value.
               iv_nxt    = (next_val != phase_incr);
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and latched configuration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase_incr <= '0;
         dwell_cnt  <= '0;
         target     <= '0;
         leg        <= 1'b0;
         incr_valid <= 1'b0;
         cfg_start  <= '0;
         cfg_step   <= '0;
         cfg_dwell  <= '0;
         cfg_pp     <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase_incr <= phase_nxt;
         dwell_cnt  <= cnt_nxt;
         target     <= target_nxt;
         leg        <= leg_nxt;
         incr_valid <= iv_nxt;
         if (load_cfg) begin
            cfg_start <= start_incr;
            cfg_step  <= step;
            cfg_dwell <= dwell;
            cfg_pp    <= pingpong;
         end
      end
   end

   assign busy = (state == DWELL);
   assign done = (state == DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;
   localparam int W  = 7;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst, start, abort, pingpong;
   logic [W-1:0]  start_incr, stop_incr, step;
   logic [DW-1:0] dwell;
   logic [W-1:0]  phase_incr;
   logic          incr_valid, busy, done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int s, e, st, dw, pp, n;
      int seq[8];
      int done_c;
   } vec_t;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   vec_t tbl[8];
   exp_t q[$];

   nco_sweep_ctrl #(.INCR_W(W), .DWELL_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .start_incr(start_incr), .stop_incr(stop_incr), .step(step),
      .dwell(dwell), .pingpong(pingpong),
      .phase_incr(phase_incr), .incr_valid(incr_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive_cfg(input vec_t v);
      start_incr = W'(v.s);
      stop_incr  = W'(v.e);
      step       = W'(v.st);
      dwell      = DW'(v.dw);
      pingpong   = (v.pp != 0);
   endtask

   // Start a sweep and score every incr_valid against the queued expectations.
   task automatic run_vec(input int i, input bit poke);
      vec_t v;
      exp_t e;
      bit   seen;
      v = tbl[i];
      q.delete();
      for (int k = 0; k < v.n; k++) q.push_back('{v.seq[k], 1 + k * (v.dw + 1)});
      @(negedge clk);
      drive_cfg(v);
      start = 1'b1;
      @(posedge clk);
      seen = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (poke && cyc == 5) begin
            start      = 1'b1;
            start_incr = W'($urandom);
            stop_incr  = W'($urandom);
            step       = W'($urandom);
            dwell      = DW'($urandom_range(0, 3));
            pingpong   = ~pingpong;
         end
         if (incr_valid) begin
            if (q.size() == 0) begin
               chk($sformatf("v%0d_extra_iv", i), int'(phase_incr), -1);
            end else begin
               e = q.pop_front();
               chk($sformatf("v%0d_val", i), int'(phase_incr), e.val);
               chk($sformatf("v%0d_iv_cyc", i), cyc, e.cyc);
            end
         end
         if (done) begin
            chk($sformatf("v%0d_done_cyc", i), cyc, v.done_c);
            chk($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
            chk($sformatf("v%0d_missing_vals", i), q.size(), 0);
            chk($sformatf("v%0d_final_val", i), int'(phase_incr), v.seq[v.n-1]);
            seen = 1'b1;
            break;
         end else begin
            chk($sformatf("v%0d_busy", i), int'(busy), 1);
         end
      end
      if (!seen) chk($sformatf("v%0d_timeout", i), 0, 1);
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_done_single", i), int'(done), 0);
      chk($sformatf("v%0d_hold_after", i), int'(phase_incr), v.seq[v.n-1]);
   endtask

   initial begin
      int  dseen;
      tbl[0] = '{10, 20, 4, 2, 0, 4, '{10, 14, 18, 20, 0, 0, 0, 0}, 13};
      tbl[1] = '{20, 12, 5, 0, 1, 5, '{20, 15, 12, 17, 20, 0, 0, 0}, 6};
      tbl[2] = '{3, 6, 0, 0, 0, 4, '{3, 4, 5, 6, 0, 0, 0, 0}, 5};
      tbl[3] = '{0, 127, 100, 0, 0, 3, '{0, 100, 127, 0, 0, 0, 0, 0}, 4};
      tbl[4] = '{127, 0, 100, 0, 0, 3, '{127, 27, 0, 0, 0, 0, 0, 0}, 4};
      tbl[5] = '{5, 5, 3, 1, 0, 1, '{5, 0, 0, 0, 0, 0, 0, 0}, 3};
      tbl[6] = '{2, 9, 3, 1, 1, 7, '{2, 5, 8, 9, 6, 3, 2, 0}, 15};
      tbl[7] = '{5, 5, 3, 1, 1, 1, '{5, 0, 0, 0, 0, 0, 0, 0}, 5};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      drive_cfg(tbl[0]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_phase", int'(phase_incr), 0);
      chk("rst_iv", int'(incr_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);

      for (int i = 0; i < 8; i++) run_vec(i, 1'b0);

      // start during DWELL with scrambled inputs must not disturb the sweep
      run_vec(0, 1'b1);

      // start and abort together in IDLE
      @(negedge clk);
      drive_cfg(tbl[1]);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", int'(busy), 0);
      chk("sa_iv", int'(incr_valid), 0);
      chk("sa_phase_held", int'(phase_incr), 20);
      @(negedge clk);
      chk("sa_still_idle", int'(busy), 0);

      // abort while phase_incr=14
      drive_cfg(tbl[0]);
      start = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("ab_pre_phase", int'(phase_incr), 14);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_busy", int'(busy), 0);
      chk("ab_phase", int'(phase_incr), 14);
      chk("ab_iv", int'(incr_valid), 0);
      dseen = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (done || busy || incr_valid) dseen++;
      end
      chk("ab_quiet", dseen, 0);
      run_vec(2, 1'b0);

      // synchronous reset mid-sweep
      drive_cfg(tbl[0]);
      start = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("rm_busy_pre", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rm_phase", int'(phase_incr), 0);
      chk("rm_iv", int'(incr_valid), 0);
      chk("rm_busy", int'(busy), 0);
      chk("rm_done", int'(done), 0);
      @(negedge clk);
      chk("rm_idle", int'(busy), 0);
      run_vec(1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
